// File: rtl/regfile_wb_stage_pkg.sv
// Shared widths, the zero-register index and the stage state type for the
// write-back stage and its register file.
package regfile_wb_stage_pkg;

   localparam int unsigned RF_DATA_W   = 32;
   localparam int unsigned RF_ADDR_W   = 5;
   localparam int unsigned RF_NUM_REGS = 32;

   localparam logic [RF_ADDR_W-1:0] REG_ZERO = '0;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } stage_state_e;

endpackage

// File: rtl/regfile_wb_stage_decoder.sv
// Binary-to-one-hot decoder with an enable; all outputs low when disabled.
module regfile_wb_stage_decoder #(
   parameter int unsigned IN_W = 5
) (
   input  logic [IN_W-1:0]      sel,
   input  logic                 en,
   output logic [2**IN_W-1:0]   onehot
);

   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[sel] = 1'b1;
      end
   end

endmodule

// File: rtl/regfile_wb_stage.sv
// Write-back stage register plus 32x32 register file with two forwarding
// read ports; r0 reads as zero and is never written.
module regfile_wb_stage
   import regfile_wb_stage_pkg::*;
#(
   parameter int unsigned DATA_W   = RF_DATA_W,
   parameter int unsigned ADDR_W   = RF_ADDR_W,
   parameter int unsigned NUM_REGS = RF_NUM_REGS
) (
   input  logic              clock,
   input  logic              ctrl_reset_n,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [ADDR_W-1:0] wb_reg,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              freeze,
   input  logic [ADDR_W-1:0] rd_reg_a,
   input  logic [ADDR_W-1:0] rd_reg_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              pending
);

   stage_state_e      state_q, state_d;
   logic [ADDR_W-1:0] s_reg_q, s_reg_d;
   logic [DATA_W-1:0] s_data_q, s_data_d;
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];

   logic              s_valid;
   logic              commit;
   logic              accept;
   logic [NUM_REGS-1:0] row_we;

   always_comb begin
      s_valid  = (state_q == ST_FULL);
      commit   = s_valid & ~freeze;
      wb_ready = ~s_valid | commit;
      accept   = wb_valid & wb_ready;
      pending  = s_valid;
   end

   regfile_wb_stage_decoder #(
      .IN_W (ADDR_W)
   ) u_row_dec (
      .sel    (s_reg_q),
      .en     (commit),
      .onehot (row_we)
   );

   // Stage FSM: accept wins over the empty transition so commit+accept stays FULL.
   always_comb begin
      state_d  = state_q;
      s_reg_d  = s_reg_q;
      s_data_d = s_data_q;
      if (accept) begin
         state_d  = ST_FULL;
         s_reg_d  = wb_reg;
         s_data_d = wb_data;
      end else if (commit) begin
         state_d  = ST_EMPTY;
      end
   end

   always_comb begin
      regs_d = regs_q;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (row_we[i] && (ADDR_W'(i) != REG_ZERO)) begin
            regs_d[i] = s_data_q;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!ctrl_reset_n) begin
         state_q  <= ST_EMPTY;
         s_reg_q  <= '0;
         s_data_q <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         s_reg_q  <= s_reg_d;
         s_data_q <= s_data_d;
         regs_q   <= regs_d;
      end
   end

   function automatic logic [DATA_W-1:0] read_port(
      input logic [ADDR_W-1:0] idx,
      input logic              fwd_valid,
      input logic [ADDR_W-1:0] fwd_reg,
      input logic [DATA_W-1:0] fwd_data,
      input logic [DATA_W-1:0] arr_data
   );
      if (idx == REG_ZERO) begin
         return '0;
      end else if (fwd_valid && (fwd_reg == idx)) begin
         return fwd_data;
      end else begin
         return arr_data;
      end
   endfunction

   always_comb begin
      rd_data_a = read_port(rd_reg_a, s_valid, s_reg_q, s_data_q, regs_q[rd_reg_a]);
      rd_data_b = read_port(rd_reg_b, s_valid, s_reg_q, s_data_q, regs_q[rd_reg_b]);
   end

endmodule

// File: tb/tb_regfile_wb_stage.sv
// Self-checking bench: directed vector table, reset corner case, then random
// traffic against an array-based reference model.
module tb_regfile_wb_stage;

   logic        clock = 1'b0;
   logic        ctrl_reset_n;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic        freeze;
   logic [4:0]  rd_reg_a;
   logic [4:0]  rd_reg_b;
   logic [31:0] rd_data_a;
   logic [31:0] rd_data_b;
   logic        pending;

   int errors = 0;
   int checks = 0;

   // reference model: committed registers plus the one-entry stage
   logic [31:0] m_r [32];
   logic        m_v;
   logic [4:0]  m_reg;
   logic [31:0] m_data;

   always #5 clock = ~clock;

   regfile_wb_stage dut (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_reg       (wb_reg),
      .wb_data      (wb_data),
      .freeze       (freeze),
      .rd_reg_a     (rd_reg_a),
      .rd_reg_b     (rd_reg_b),
      .rd_data_a    (rd_data_a),
      .rd_data_b    (rd_data_b),
      .pending      (pending)
   );

   typedef struct {
      logic        v;
      logic [4:0]  r;
      logic [31:0] d;
      logic        f;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic        e_ready;
      logic        e_pend;
      logic [31:0] e_a;
      logic [31:0] e_b;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d,
                        input logic f, input logic [4:0] ra, input logic [4:0] rb);
      wb_valid = v; wb_reg = r; wb_data = d; freeze = f;
      rd_reg_a = ra; rd_reg_b = rb;
      #1;
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (m_v && m_reg == idx) return m_data;
      return m_r[idx];
   endfunction

   // Advance one clock, applying the architectural edge rules to the model.
   task automatic tick();
      logic rdy, cmt, acc;
      if (!ctrl_reset_n) begin
         for (int i = 0; i < 32; i++) m_r[i] = '0;
         m_v = 1'b0; m_reg = '0; m_data = '0;
      end else begin
         cmt = m_v && !freeze;
         rdy = !m_v || cmt;
         acc = wb_valid && rdy;
         if (cmt && m_reg != 5'd0) m_r[m_reg] = m_data;
         if (acc) begin
            m_v = 1'b1; m_reg = wb_reg; m_data = wb_data;
         end else if (cmt) begin
            m_v = 1'b0;
         end
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      //          v  reg    data          f  ra     rb     rdy pend a             b
      vecs[0]  = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd5, 5'd0, 1, 0, 32'h0,        32'h0};
      vecs[1]  = '{0, 5'd0, 32'h0,        0, 5'd5, 5'd5, 1, 1, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[2]  = '{1, 5'd3, 32'h1,        0, 5'd5, 5'd3, 1, 0, 32'hDEADBEEF, 32'h0};
      vecs[3]  = '{1, 5'd3, 32'h2,        0, 5'd3, 5'd5, 1, 1, 32'h1,        32'hDEADBEEF};
      vecs[4]  = '{1, 5'd4, 32'h3,        0, 5'd3, 5'd4, 1, 1, 32'h2,        32'h0};
      vecs[5]  = '{1, 5'd7, 32'h55,       0, 5'd3, 5'd4, 1, 1, 32'h2,        32'h3};
      vecs[6]  = '{1, 5'd8, 32'h66,       1, 5'd7, 5'd4, 0, 1, 32'h55,       32'h3};
      vecs[7]  = '{1, 5'd8, 32'h66,       1, 5'd7, 5'd8, 0, 1, 32'h55,       32'h0};
      vecs[8]  = '{1, 5'd8, 32'h66,       0, 5'd7, 5'd8, 1, 1, 32'h55,       32'h0};
      vecs[9]  = '{0, 5'd0, 32'h0,        0, 5'd7, 5'd8, 1, 1, 32'h55,       32'h66};
      vecs[10] = '{1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 5'd8, 1, 0, 32'h0,        32'h66};
      vecs[11] = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 1, 1, 32'h0,        32'h0};
      vecs[12] = '{1, 5'd9, 32'hA5,       1, 5'd0, 5'd9, 1, 0, 32'h0,        32'h0};
      vecs[13] = '{0, 5'd0, 32'h0,        1, 5'd9, 5'd9, 0, 1, 32'hA5,       32'hA5};
      vecs[14] = '{0, 5'd0, 32'h0,        0, 5'd9, 5'd0, 1, 1, 32'hA5,       32'h0};
      vecs[15] = '{1, 5'd9, 32'h77,       0, 5'd9, 5'd3, 1, 0, 32'hA5,       32'h2};

      for (int i = 0; i < 32; i++) m_r[i] = '0;
      m_v = 1'b0; m_reg = '0; m_data = '0;

      ctrl_reset_n = 1'b0;
      drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
      tick();
      tick();
      ctrl_reset_n = 1'b1;

      drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
      chk("reset_ready", {31'd0, wb_ready}, 32'd1);
      chk("reset_pending", {31'd0, pending}, 32'd0);
      for (int i = 0; i < 32; i++) begin
         drive(0, 5'd0, 32'h0, 0, 5'(i), 5'(31 - i));
         chk("reset_rd_a", rd_data_a, 32'h0);
         chk("reset_rd_b", rd_data_b, 32'h0);
      end

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].v, vecs[i].r, vecs[i].d, vecs[i].f, vecs[i].ra, vecs[i].rb);
         chk($sformatf("vec%0d_ready", i), {31'd0, wb_ready}, {31'd0, vecs[i].e_ready});
         chk($sformatf("vec%0d_pending", i), {31'd0, pending}, {31'd0, vecs[i].e_pend});
         chk($sformatf("vec%0d_rd_a", i), rd_data_a, vecs[i].e_a);
         chk($sformatf("vec%0d_rd_b", i), rd_data_b, vecs[i].e_b);
         tick();
      end

      // reg9=0x77 now pending; reset on this edge must drop it unwritten
      drive(0, 5'd0, 32'h0, 0, 5'd9, 5'd9);
      chk("prereset_pending", {31'd0, pending}, 32'd1);
      chk("prereset_rd9", rd_data_a, 32'h77);
      ctrl_reset_n = 1'b0;
      tick();
      ctrl_reset_n = 1'b1;
      drive(0, 5'd0, 32'h0, 0, 5'd9, 5'd5);
      chk("postreset_pending", {31'd0, pending}, 32'd0);
      chk("postreset_rd9", rd_data_a, 32'h0);
      chk("postreset_rd5", rd_data_b, 32'h0);
      drive(0, 5'd0, 32'h0, 0, 5'd3, 5'd7);
      chk("postreset_rd3", rd_data_a, 32'h0);
      chk("postreset_rd7", rd_data_b, 32'h0);

      for (int n = 0; n < 2000; n++) begin
         ctrl_reset_n = ($urandom_range(99) != 0);
         drive($urandom_range(3) != 0, 5'($urandom_range(31)), $urandom,
               $urandom_range(9) < 3, 5'($urandom_range(31)), 5'($urandom_range(31)));
         chk("rand_ready", {31'd0, wb_ready}, {31'd0, (!m_v || !freeze)});
         chk("rand_pending", {31'd0, pending}, {31'd0, m_v});
         chk("rand_rd_a", rd_data_a, m_read(rd_reg_a));
         chk("rand_rd_b", rd_data_b, m_read(rd_reg_b));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
